mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter L_WORD, default 4: operand width in bits; product width is 2*L_WORD.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 multiply request, level.
REQ-005 a0, b0  input  L_WORD each  requester 0 multiplicand and multiplier.
REQ-006 req1  input  1  requester 1 multiply request, level.
REQ-007 a1, b1  input  L_WORD each  requester 1 multiplicand and multiplier.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; product valid.
REQ-011 done_id  output  1  requester owning the current or most recent result (0/1).
REQ-012 product  output  2*L_WORD  unsigned result; holds until the next grant.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, plus an internal shift-add datapath: 2*L_WORD multiplicand register, L_WORD multiplier register, 2*L_WORD accumulator, step counter.
REQ-014 In IDLE, at a clock edge with any req high, the block SHALL grant exactly one requester; with none high it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; last-granted SHALL reset to 1, so req0 wins the first contention.
REQ-016 At the grant edge: pulse gnt of the winner for exactly one cycle; latch a into the multiplicand (zero-extended) and b into the multiplier; clear product and counter; set done_id to the winner.
REQ-017 If the latched a or b is zero (early termination), the FSM SHALL go from IDLE directly to DONE with product 0.
REQ-018 Otherwise it SHALL go to RUN and perform exactly L_WORD steps, one per edge.
REQ-019 Each RUN step: if multiplier[0]=1, product += multiplicand; then shift multiplier right by 1 and multiplicand left by 1.
REQ-020 After the L_WORD-th step the FSM SHALL go to DONE; done SHALL be high for the single DONE cycle; the next edge SHALL return to IDLE.
REQ-021 Latency: done is asserted L_WORD+1 cycles after the gnt cycle begins (5 for L_WORD=4); with early termination it is the cycle immediately after gnt.
REQ-022 Requests SHALL be ignored outside IDLE; a request held high SHALL remain pending and be arbitrated in the next IDLE cycle.
REQ-023 Requesters SHALL hold req, a and b stable until their gnt, then drop req in the gnt cycle; a req still high in IDLE is a new request.
REQ-024 Product arithmetic SHALL be unsigned and exact for all operands (max (2^L_WORD-1)^2), with no overflow or truncation.
REQ-025 busy SHALL be 0 in IDLE and 1 in RUN and DONE; gnt0 and gnt1 SHALL never be high together.
REQ-026 product and done_id SHALL remain stable from the DONE cycle until the next grant edge.

Reset
REQ-027 While reset is high: state IDLE; gnt0, gnt1, busy, done, done_id and product at 0; internal registers and counter at 0; last-granted at 1.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately: no done pulse, result discarded.
REQ-029 After reset deasserts, arbitration SHALL start from the reset state, with no memory of the aborted requester.

Verification
REQ-030 L_WORD=4, req0 with a0=3, b0=5 -> gnt0 one cycle; busy; done 5 cycles later; product=15; done_id=0.
REQ-031 req0 and req1 both high from reset release (a0=2,b0=7; a1=4,b1=6) -> gnt0 first with product 14, then gnt1 in the next IDLE with product 24; done_id 0 then 1.
REQ-032 req1 with a1=9, b1=0 -> gnt1, done in the next cycle, product=0, total busy time 1 cycle.
REQ-033 req0 with a0=15, b0=15 -> product=225 (8'hE1) after 5 cycles.
REQ-034 Reset pulse 2 cycles into RUN -> all outputs 0, no done pulse; a subsequent req1 alone -> gnt1 and correct product.
REQ-035 req0 and req1 held high continuously for 4 operations -> grants alternate 0,1,0,1; never both grants high; product correct each time.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Two-requester shared shift-add multiplier with round-robin arbitration.
// One operation at a time: IDLE grants, RUN does L_WORD shift-add steps, DONE pulses the result.
module mult_share_arbiter #(
    parameter int L_WORD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [L_WORD-1:0]     a0,
    input  logic [L_WORD-1:0]     b0,
    input  logic                  req1,
    input  logic [L_WORD-1:0]     a1,
    input  logic [L_WORD-1:0]     b1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [2*L_WORD-1:0]   product
);

    localparam int CNT_W = $clog2(L_WORD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [2*L_WORD-1:0]   mcand;
    logic [L_WORD-1:0]     mplier;
    logic [2*L_WORD-1:0]   acc;
    logic [CNT_W-1:0]      cnt;
    logic                  last;
    logic                  id;

    logic                  pick0, pick1;
    logic                  gnt0_c, gnt1_c;
    logic [L_WORD-1:0]     sel_a, sel_b;
    logic                  grant;

    // Round-robin: under contention the requester not granted last wins.
    assign pick0 = req0 & (~req1 | last);
    assign pick1 = req1 & (~req0 | ~last);
    assign sel_a = pick1 ? a1 : a0;
    assign sel_b = pick1 ? b1 : b0;

    always_comb begin
        state_nxt = state;
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    gnt0_c = pick0;
                    gnt1_c = pick1;
                    // A zero operand skips the shift-add loop entirely.
                    if (sel_a == '0 || sel_b == '0)
                        state_nxt = DONE;
                    else
                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(L_WORD - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are combinational in the last IDLE cycle; reset masks them immediately.
    assign gnt0    = gnt0_c & ~reset;
    assign gnt1    = gnt1_c & ~reset;
    assign grant   = gnt0 | gnt1;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign done_id = id;
    assign product = acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            last   <= 1'b1;
            id     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant) begin
                mcand  <= {{L_WORD{1'b0}}, sel_a};
                mplier <= sel_b;
                acc    <= '0;
                cnt    <= '0;
                id     <= pick1;
                last   <= pick1;
            end else if (state == RUN) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mplier <= mplier >> 1;
                mcand  <= mcand << 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter against a transaction-level model
// (remaining-busy-cycles count, round-robin pointer, product = a*b).
module tb_mult_share_arbiter;

    localparam int L = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             req0, req1;
    logic [L-1:0]     a0, b0, a1, b1;
    logic             gnt0, gnt1, busy, done, done_id;
    logic [2*L-1:0]   product;

    mult_share_arbiter #(.L_WORD(L)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .product(product)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state
    int  rem;          // cycles of busy remaining (0 = idle)
    int  m_prod;
    int  m_id;
    int  m_last;
    bit  hold0, hold1; // requester keeps req high after its grant
    bit  w0, w1;
    int  grant_log[$];
    int  done_count;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        rem = 0; m_prod = 0; m_id = 0; m_last = 1;
    endtask

    // One clock: check at negedge, advance model at posedge, drive at posedge+1.
    task automatic cycle();
        @(negedge clock);
        w0 = !reset && rem == 0 && req0 && (!req1 || m_last == 1);
        w1 = !reset && rem == 0 && req1 && (!req0 || m_last == 0);
        check("gnt0", int'(gnt0), int'(w0));
        check("gnt1", int'(gnt1), int'(w1));
        check("gnt_excl", int'(gnt0 & gnt1), 0);
        check("busy", int'(busy), int'(rem != 0));
        check("done", int'(done), int'(rem == 1));
        check("done_id", int'(done_id), m_id);
        if (rem <= 1)
            check("product", int'(product), m_prod);
        if (rem == 1) done_count++;
        @(posedge clock);
        if (!reset) begin
            if (rem > 0) begin
                rem--;
            end else if (w0 || w1) begin
                m_id   = w1 ? 1 : 0;
                m_last = m_id;
                grant_log.push_back(m_id);
                m_prod = w1 ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
                rem    = (m_prod == 0) ? 1 : L + 1;
            end
        end
        #1;
        if (w0 && !hold0) req0 = 1'b0;
        if (w1 && !hold1) req1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rem != 0 || req0 || req1) && n < 200) begin
            cycle();
            n++;
        end
        check("drain_timeout", int'(n < 200), 1);
        cycle();
    endtask

    task automatic issue(input int who, input int a, input int b);
        if (who == 0) begin req0 = 1'b1; a0 = L'(a); b0 = L'(b); end
        else          begin req1 = 1'b1; a1 = L'(a); b1 = L'(b); end
    endtask

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        hold0 = 0; hold1 = 0; done_count = 0;
        model_reset();
        // Contention present while still in reset: no grants may appear.
        issue(0, 2, 7);
        issue(1, 4, 6);
        repeat (3) cycle();
        reset = 1'b0;
        grant_log.delete();
        drain();
        check("contend_n", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("contend_first", grant_log[0], 0);
            check("contend_second", grant_log[1], 1);
        end
        check("contend_last_prod", int'(product), 24);

        issue(0, 3, 5);   drain(); check("p_3x5", int'(product), 15);
        issue(1, 9, 0);   drain(); check("p_9x0", int'(product), 0);
        check("id_9x0", int'(done_id), 1);
        issue(0, 15, 15); drain(); check("p_15x15", int'(product), 225);
        issue(1, 0, 11);  drain(); check("p_0x11", int'(product), 0);

        // Abort mid-RUN, then req1 alone after release.
        done_count = 0;
        issue(0, 7, 9);
        repeat (3) cycle();
        reset = 1'b1;
        req0 = 1'b0;
        model_reset();
        repeat (2) cycle();
        check("abort_prod", int'(product), 0);
        check("abort_done_cnt", done_count, 0);
        reset = 1'b0;
        issue(1, 6, 13);
        drain();
        check("after_abort", int'(product), 78);
        check("after_abort_id", int'(done_id), 1);

        // Both held high: grants must alternate.
        grant_log.delete();
        hold0 = 1; hold1 = 1;
        issue(0, 11, 3);
        issue(1, 5, 14);
        for (int i = 0; i < 200 && grant_log.size() < 4; i++) cycle();
        hold0 = 0; hold1 = 0; req0 = 0; req1 = 0;
        drain();
        check("alt_n", int'(grant_log.size() >= 4), 1);
        for (int i = 0; i < grant_log.size(); i++)
            check("alt_order", grant_log[i], i % 2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (!req0 && $urandom_range(0, 2) == 0)
                issue(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if (!req1 && $urandom_range(0, 2) == 0)
                issue(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
